// File: rtl/minimig_bankmap_pipe.sv
`default_nettype none
// ============================================================================
// Module  : minimig_bankmap_pipe
// Purpose : Registered chip/slow/kick bank mapper with chipram mirroring and
//           drain-synchronised memory-config updates (valid/ready handshake).
// Revision: 1.0 - initial release
// ============================================================================
module minimig_bankmap_pipe #(
  parameter int CHIP_N = 4,
  parameter int SLOW_N = 3,
  parameter int CFG_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CHIP_N-1:0]   req_chip,
  input  logic [SLOW_N-1:0]   req_slow,
  input  logic                req_kick,
  input  logic                req_kick1mb,
  input  logic                req_kickmirror,
  input  logic                req_cart,
  input  logic [CFG_W-1:0]    cfg_in,
  input  logic                cfg_update,
  output logic [CFG_W-1:0]    cfg_active,
  output logic                cfg_busy,
  output logic                bank_valid,
  input  logic                bank_ready,
  output logic [CHIP_N+3:0]   bank,
  output logic                bank_unmapped,
  output logic                err_multi
);

  localparam int              BANK_W  = CHIP_N + 4;
  localparam logic [CFG_W-1:0] CFG_MAX = CFG_W'(CHIP_N - 1);

  function automatic logic [CFG_W-1:0] clamp_cfg(input logic [CFG_W-1:0] v);
    return (v > CFG_MAX) ? CFG_MAX : v;
  endfunction

  logic [CFG_W-1:0]  cfg_pending;
  logic              out_free;
  logic              xfer;
  logic              apply;
  logic              multi_hit;
  logic [3:0]        n_blk;
  logic [3:0]        p_blk;
  logic [CHIP_N-1:0] chip_bank;
  logic              chip_unmapped;
  logic [BANK_W-1:0] bank_next;

  assign out_free  = !bank_valid || bank_ready;
  assign req_ready = !cfg_busy && out_free;
  assign xfer      = req_valid && req_ready;
  // Config swaps only when the output stage is free and requests are blocked
  assign apply     = cfg_busy && out_free;
  assign multi_hit = |(req_chip & (req_chip - CHIP_N'(1)));

  // Mirror chip blocks modulo the next power of two above the configured size
  always_comb begin
    n_blk         = 4'(clamp_cfg(cfg_active)) + 4'd1;
    p_blk         = 4'd1;
    chip_bank     = '0;
    chip_unmapped = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (p_blk < n_blk) p_blk = p_blk << 1;
    end
    for (int i = 0; i < CHIP_N; i++) begin
      if (req_chip[i]) begin
        if ((4'(i) & (p_blk - 4'd1)) >= n_blk) begin
          chip_unmapped = 1'b1;
        end else begin
          for (int j = 0; j < CHIP_N; j++) begin
            if (4'(j) == (4'(i) & (p_blk - 4'd1))) chip_bank[j] = 1'b1;
          end
        end
      end
    end
  end

  assign bank_next = {req_kick, req_kickmirror, |req_chip,
                      req_kick1mb | req_cart | (|req_slow), chip_bank};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bank_valid    <= 1'b0;
      bank          <= '0;
      bank_unmapped <= 1'b0;
      err_multi     <= 1'b0;
    end else begin
      if (xfer) begin
        bank_valid    <= 1'b1;
        bank          <= bank_next;
        bank_unmapped <= chip_unmapped;
        if (multi_hit) err_multi <= 1'b1;
      end else if (bank_ready) begin
        bank_valid    <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_pending <= '0;
      cfg_active  <= '0;
      cfg_busy    <= 1'b0;
    end else begin
      if (apply) cfg_active <= cfg_pending;
      if (cfg_update) begin
        cfg_pending <= clamp_cfg(cfg_in);
        cfg_busy    <= 1'b1;
      end else if (apply) begin
        cfg_busy    <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
